// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer, the datapath muxes and ALU control.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_OPIMM, CLS_OP,
    CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
  } opc_class_e;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_IMM  = 2'b01;
  localparam logic [1:0] WB_MEM  = 2'b10;
  localparam logic [1:0] WB_LINK = 2'b11;

  localparam logic PC_PLUS4 = 1'b0;
  localparam logic PC_ALU   = 1'b1;

  function automatic opc_class_e classify(input logic [6:0] opc);
    case (opc)
      OPC_LUI:    classify = CLS_LUI;
      OPC_AUIPC:  classify = CLS_AUIPC;
      OPC_JAL:    classify = CLS_JAL;
      OPC_OPIMM:  classify = CLS_OPIMM;
      OPC_OP:     classify = CLS_OP;
      OPC_LOAD:   classify = CLS_LOAD;
      OPC_STORE:  classify = CLS_STORE;
      OPC_BRANCH: classify = CLS_BRANCH;
      default:    classify = CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_mem_timeout.sv
// Counts consecutive stalled memory-request cycles; expired flags the last
// tolerated stall cycle so the sequencer can trap on the following edge.
module mc_mem_timeout #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  input  logic state_change,
  output logic expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // A ready in the same cycle completes the access, so it masks expiry.
  assign expired = req && !ready && (cnt_q >= TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (ready || state_change || !req) cnt_d = '0;
    else if (!expired)                 cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_ctrl_seq.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake.
// Optional MC_CTRL_SEQ_PERF_EN adds retired_cnt / cycle_cnt performance counters.
module mc_ctrl_seq
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic [1:0]  wb_sel,
  output logic        reg_write,
  output logic        trap,
`ifdef MC_CTRL_SEQ_PERF_EN
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt,
`endif
  output logic [2:0]  state
);

  state_e     state_q, state_d;
  opc_class_e cls_q, cls_d;
  logic       expired;
  logic       state_change;

  assign state_change = (state_d != state_q);
  assign state        = state_q;

  mc_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timeout (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (mem_req),
    .ready        (mem_ready),
    .state_change (state_change),
    .expired      (expired)
  );

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (expired) state_d = S_TRAP;
      end
      S_DECODE: begin
        cls_d   = classify(opcode);
        state_d = (cls_d == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          CLS_BRANCH:          state_d = S_FETCH;
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready)    state_d = (cls_q == CLS_STORE) ? S_FETCH : S_WB;
        else if (expired) state_d = S_TRAP;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_ILLEGAL;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Moore decode of state and latched class; only FETCH and EXEC/BRANCH look at inputs.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    wb_sel    = WB_ALU;
    reg_write = 1'b0;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        case (cls_q)
          CLS_OP:    alu_op = ALU_RFUNCT;
          CLS_OPIMM: begin alu_op = ALU_IFUNCT; alu_src = 1'b1; end
          CLS_LOAD, CLS_STORE, CLS_AUIPC: alu_src = 1'b1;
          CLS_JAL: begin
            alu_src  = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_ALU;
          end
          CLS_BRANCH: begin
            alu_op   = ALU_SUB;
            pc_write = branch_taken;
            pc_src   = PC_ALU;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls_q == CLS_STORE);
        alu_src  = 1'b1;
      end
      S_WB: begin
        reg_write = 1'b1;
        case (cls_q)
          CLS_LUI:  wb_sel = WB_IMM;
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL:  wb_sel = WB_LINK;
          default:  wb_sel = WB_ALU;
        endcase
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

`ifdef MC_CTRL_SEQ_PERF_EN
  logic [31:0] retired_q, cycle_q;
  logic        retire;

  // An instruction retires on its final cycle, whichever state that is.
  assign retire = (state_q == S_WB)
               || (state_q == S_MEM  && cls_q == CLS_STORE && mem_ready)
               || (state_q == S_EXEC && cls_q == CLS_BRANCH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_q   <= cycle_q + 32'd1;
      if (retire)            retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Bench for mc_ctrl_seq: per-instruction cycle scripts built from the ISA timing rules,
// replayed against the DUT with a full output compare on every cycle.
module tb_mc_ctrl_seq;

  localparam int TO = 16;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                         OPIMM = 7'b0010011, OP = 7'b0110011, LOAD = 7'b0000011,
                         STORE = 7'b0100011, BRANCH = 7'b1100011;
  localparam logic [6:0] OPS [8] = '{LUI, AUIPC, JAL, OPIMM, OP, LOAD, STORE, BRANCH};

  logic       clk = 1'b0;
  logic       rst_n, branch_taken, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src, reg_write, trap;
  logic [1:0] alu_op, wb_sel;
  logic [2:0] state;
`ifdef MC_CTRL_SEQ_PERF_EN
  logic [31:0] retired_cnt, cycle_cnt;
`endif

  always #5 clk = ~clk;

  mc_ctrl_seq #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src(alu_src), .wb_sel(wb_sel), .reg_write(reg_write), .trap(trap),
`ifdef MC_CTRL_SEQ_PERF_EN
    .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt),
`endif
    .state(state)
  );

  typedef struct {
    logic [2:0] st;
    logic       req, we, asel, irw, pcw, pcs;
    logic [1:0] aop;
    logic       asrc;
    logic [1:0] wbs;
    logic       rw, trp;
    logic       rdy, bt, rstn, chk, last;
    logic [6:0] opc;
  } cyc_t;

  cyc_t plan[$];
  int   tests = 0;
  int   fails = 0;

  function automatic bit legal(input logic [6:0] o);
    return o inside {LUI, AUIPC, JAL, OPIMM, OP, LOAD, STORE, BRANCH};
  endfunction

  // Quiet cycle: every output low; unused inputs carry random noise.
  function automatic cyc_t base(input logic [2:0] st, input logic [6:0] opc);
    cyc_t c;
    c.st = st; c.req = 0; c.we = 0; c.asel = 0; c.irw = 0; c.pcw = 0; c.pcs = 0;
    c.aop = 2'b00; c.asrc = 0; c.wbs = 2'b00; c.rw = 0; c.trp = 0;
    c.rdy = 1'($urandom); c.bt = 1'($urandom); c.rstn = 1; c.chk = 1; c.last = 0;
    c.opc = opc;
    return c;
  endfunction

  function automatic cyc_t fetch_cyc(input logic rdy);
    cyc_t c = base(3'd0, 7'($urandom));
    c.req = 1; c.rdy = rdy; c.irw = rdy; c.pcw = rdy;
    return c;
  endfunction

  function automatic cyc_t mem_cyc(input logic [6:0] opc, input logic rdy);
    cyc_t c = base(3'd3, opc);
    c.req = 1; c.asel = 1; c.we = (opc == STORE); c.asrc = 1; c.rdy = rdy;
    c.last = rdy && (opc == STORE);
    return c;
  endfunction

  // Appends one instruction's cycles; returns 1 if it ends heading into TRAP.
  function automatic bit add_instr(input logic [6:0] opc, input bit bt, input int fw,
                                   input int mw, input bit rst_in_mem);
    cyc_t c;
    for (int i = 0; i < fw && i < TO; i++) plan.push_back(fetch_cyc(1'b0));
    if (fw >= TO) return 1;
    plan.push_back(fetch_cyc(1'b1));
    plan.push_back(base(3'd1, opc));
    if (!legal(opc)) return 1;
    c = base(3'd2, opc);
    case (opc)
      OP:                       begin c.aop = 2'b10; c.asrc = 0; end
      OPIMM:                    begin c.aop = 2'b11; c.asrc = 1; end
      LOAD, STORE, AUIPC, JAL:  begin c.aop = 2'b00; c.asrc = 1; end
      BRANCH:                   begin c.aop = 2'b01; c.asrc = 0; end
      default:                  begin c.aop = 2'b00; c.asrc = 0; end
    endcase
    if (opc == BRANCH) begin
      c.bt = bt; c.pcs = 1; c.pcw = bt; c.last = 1;
      plan.push_back(c);
      return 0;
    end
    if (opc == JAL) begin c.pcs = 1; c.pcw = 1; end
    plan.push_back(c);
    if (opc == LOAD || opc == STORE) begin
      for (int i = 0; i < mw && i < TO; i++) plan.push_back(mem_cyc(opc, 1'b0));
      if (mw >= TO) return 1;
      if (rst_in_mem) begin
        c = mem_cyc(opc, 1'b0);
        c.rstn = 0;
        plan.push_back(c);
        return 0;
      end
      plan.push_back(mem_cyc(opc, 1'b1));
      if (opc == STORE) return 0;
    end
    c = base(3'd4, opc);
    c.rw = 1; c.last = 1;
    c.wbs = (opc == LUI) ? 2'b01 : (opc == LOAD) ? 2'b10 : (opc == JAL) ? 2'b11 : 2'b00;
    plan.push_back(c);
    return 0;
  endfunction

  function automatic void add_trap_then_reset(input int n);
    cyc_t c;
    for (int i = 0; i <= n; i++) begin
      c = base(3'd5, 7'($urandom));
      c.trp = 1;
      if (i == n) c.rstn = 0;
      plan.push_back(c);
    end
  endfunction

  task automatic pin(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic run_plan();
    int          n = 0;
    logic [31:0] ecyc = 0, eret = 0;
    logic [15:0] got, exp;
    cyc_t        c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(negedge clk);
      rst_n = c.rstn; mem_ready = c.rdy; branch_taken = c.bt; opcode = c.opc;
      #1;
      if (c.chk) begin
        got = {state, mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               alu_op, alu_src, wb_sel, reg_write, trap};
        exp = {c.st, c.req, c.we, c.asel, c.irw, c.pcw, c.pcs,
               c.aop, c.asrc, c.wbs, c.rw, c.trp};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL cyc%0d outputs got=%h exp=%h (opc=%b rdy=%b)", n, got, exp, c.opc, c.rdy);
        end
`ifdef MC_CTRL_SEQ_PERF_EN
        tests++;
        if (retired_cnt !== eret || cycle_cnt !== ecyc) begin
          fails++;
          $display("FAIL cyc%0d perf got=%0d/%0d exp=%0d/%0d", n, retired_cnt, cycle_cnt, eret, ecyc);
        end
`endif
      end
      if (!c.rstn) begin
        ecyc = 0; eret = 0;
      end else begin
        if (c.st != 3'd5) ecyc = ecyc + 1;
        if (c.last)       eret = eret + 1;
      end
      n++;
    end
  endtask

  initial begin
    cyc_t c;
    int   sz;
    bit   tr;
    logic [6:0] o;
    int   r, fw, mw;
    rst_n = 0; mem_ready = 0; branch_taken = 0; opcode = 7'd0;

    c = base(3'd0, 7'd0); c.rstn = 0; c.rdy = 0; c.chk = 0; plan.push_back(c);
    c = fetch_cyc(1'b0); c.rstn = 0; plan.push_back(c);

    sz = plan.size(); tr = add_instr(OP, 0, 0, 0, 0);
    pin("op_len", plan.size() - sz, 4);
    pin("op_exec_aluop", int'(plan[sz+2].aop), 2);
    pin("op_wb_rw", int'(plan[sz+3].rw), 1);

    sz = plan.size(); tr = add_instr(LOAD, 0, 0, 3, 0);
    pin("load_len", plan.size() - sz, 8);
    pin("load_wbsel", int'(plan[sz+7].wbs), 2);

    sz = plan.size(); tr = add_instr(BRANCH, 1, 0, 0, 0);
    pin("br_t_len", plan.size() - sz, 3);
    pin("br_t_pcw", int'(plan[sz+2].pcw), 1);
    sz = plan.size(); tr = add_instr(BRANCH, 0, 0, 0, 0);
    pin("br_nt_pcw", int'(plan[sz+2].pcw), 0);

    sz = plan.size(); tr = add_instr(7'b1111111, 0, 0, 0, 0);
    pin("illegal_trap", int'(tr), 1);
    pin("illegal_len", plan.size() - sz, 2);
    add_trap_then_reset(4);

    sz = plan.size(); tr = add_instr(OP, 0, TO, 0, 0);
    pin("fetch_to_trap", int'(tr), 1);
    pin("fetch_to_len", plan.size() - sz, 16);
    add_trap_then_reset(2);

    sz = plan.size(); tr = add_instr(OP, 0, TO - 1, 0, 0);
    pin("fetch_15_notrap", int'(tr), 0);
    pin("fetch_15_decode", int'(plan[sz+16].st), 1);

    sz = plan.size(); tr = add_instr(STORE, 0, 0, 2, 1);
    pin("store_rst_len", plan.size() - sz, 6);
    tr = add_instr(AUIPC, 0, 0, 0, 0);

    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 39);
      if (r == 39) begin
        do o = 7'($urandom); while (legal(o));
      end else o = OPS[$urandom_range(0, 7)];
      r  = $urandom_range(0, 31);
      fw = (r < 20) ? 0 : (r < 29) ? $urandom_range(1, 3) : (r == 29) ? 15 : (r == 30) ? 16 : 20;
      r  = $urandom_range(0, 31);
      mw = (r < 18) ? 0 : (r < 29) ? $urandom_range(1, 4) : (r == 29) ? 15 : (r == 30) ? 16 : 18;
      tr = add_instr(o, 1'($urandom), fw, mw, $urandom_range(0, 24) == 0);
      if (tr) add_trap_then_reset($urandom_range(1, 3));
    end

    run_plan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
